// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit.
// Op codes follow Funct3; the FSM states are shared with debug tooling.
package muldiv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: shift-add multiply and restoring
// divide on one shared XLEN+1 bit adder, with a start/busy/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN);

    md_state_t         state;
    md_op_t            op;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg;

    md_op_t            in_op;
    logic              sa;
    logic              sb;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special;

    logic              is_mul;
    logic [XLEN:0]     add_x;
    logic [XLEN:0]     add_y;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   dword;
    logic [XLEN-1:0]   fix_word;

    always_comb begin
        in_op    = md_op_t'(Funct3);
        sa       = in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sb       = in_op inside {OP_MULH, OP_DIV, OP_REM};
        a_neg    = sa & SrcA[XLEN-1];
        b_neg    = sb & SrcB[XLEN-1];
        mag_a    = a_neg ? -SrcA : SrcA;
        mag_b    = b_neg ? -SrcB : SrcB;
        div_zero = in_op[2] && (SrcB == '0);
        div_ovf  = (in_op == OP_DIV || in_op == OP_REM)
                && (SrcA == {1'b1, {(XLEN-1){1'b0}}})
                && (SrcB == '1);
        // Overflowing DIV returns the dividend unchanged, so SrcA covers it
        if (in_op[1])
            special = div_zero ? SrcA : '0;
        else
            special = div_zero ? '1 : SrcA;
    end

    // Multiply adds into the upper half; divide trial-subtracts the divisor
    always_comb begin
        is_mul   = ~op[2];
        add_x    = is_mul ? {1'b0, acc[2*XLEN-1:XLEN]}
                          : acc[2*XLEN-1:XLEN-1];
        add_y    = is_mul ? (acc[0] ? {1'b0, opnd} : '0)
                          : ~{1'b0, opnd};
        sum      = add_x + add_y + {{XLEN{1'b0}}, ~is_mul};
        mul_next = {sum, acc[XLEN-1:1]};
        if (sum[XLEN])
            div_next = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
        else
            div_next = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    always_comb begin
        full  = neg ? -acc : acc;
        dword = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op[2])
            fix_word = neg ? -dword : dword;
        else if (op == OP_MUL)
            fix_word = full[XLEN-1:0];
        else
            fix_word = full[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op     <= OP_MUL;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg    <= 1'b0;
            Result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op    <= in_op;
                        count <= CW'(XLEN-1);
                        if (div_zero || div_ovf) begin
                            Result <= special;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                            opnd  <= in_op[2] ? mag_b : mag_a;
                            acc   <= {{XLEN{1'b0}}, in_op[2] ? mag_a : mag_b};
                            neg   <= (in_op[2] && in_op[1]) ? a_neg
                                                            : a_neg ^ b_neg;
                        end
                    end
                end
                CALC: begin
                    acc <= is_mul ? mul_next : div_next;
                    if (count == '0)
                        state <= FIX;
                    else
                        count <= count - 1'b1;
                end
                FIX: begin
                    Result <= fix_word;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: handshake timing, results and
// special cases against hand-computed values.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] Result;

    int total = 0;
    int passed = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_done,
                          input bit disturb);
        int done_at;
        int done_n;
        int busy_n;
        done_at = -1;
        done_n  = 0;
        busy_n  = 0;
        @(negedge clk);
        start  = 1'b1;
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (disturb && c >= 5 && c <= 20) begin
                start  = 1'b1;
                Funct3 = 3'b000;
                SrcA   = 32'h0000_0003;
                SrcB   = 32'h0000_0005;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
        end
        check({tag, " done_cycle"}, done_at, exp_done);
        check({tag, " done_count"}, done_n, 1);
        check({tag, " busy_cycles"}, busy_n, exp_done);
        check({tag, " result"}, Result, exp_r);
    endtask

    initial begin
        int late_done;
        reset  = 1'b1;
        start  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'b0, busy}, 0);
        check("reset done", {31'b0, done}, 0);
        check("reset result", Result, 0);
        reset = 1'b0;

        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 34, 0);
        run_op("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 34, 0);
        run_op("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000,
               32'hC000_0000, 34, 0);
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 0);
        run_op("divu_by0", 3'b101, 32'd55, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem_by0", 3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678, 1, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 1, 0);
        run_op("div_ignore", 3'b100, 32'd100, 32'd7, 32'd14, 34, 1);

        // Abort a multiply with reset in cycle 10
        @(negedge clk);
        start  = 1'b1;
        Funct3 = 3'b000;
        SrcA   = 32'd9;
        SrcB   = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'b0, busy}, 0);
        check("abort done", {31'b0, done}, 0);
        check("abort result", Result, 0);
        late_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("abort no_done", late_done, 0);

        run_op("after_reset", 3'b000, 32'd12, 32'd11, 32'd132, 34, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
